sr_latch_driver: RTL and testbench

- Synchronous initiator for a gated SR latch (S, R, enable C, readback Q/nQ).
- Turns single-cycle set/clear/refresh commands into well-formed timed sequences on S/R/C.
- S and R are never high together, and S/R only change while C is high.
- Samples Q/nQ while C is still high, confirms the result, and reports done or error.
- Sits between control logic and any latch-based storage cell in the design.

---
 rtl/sr_latch_driver_if.sv | 28 ++
 rtl/sr_latch_driver.sv | 195 +++++++++++++++++++
 tb/tb_sr_latch_driver.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_driver_if.sv
// Command/readback bundle between an initiator and sr_latch_driver.
// master: environment side (controller issuing commands + the latch cell feeding Q/nQ back).
// slave : sr_latch_driver side (accepts commands, drives S/R/C, reports done/errors/state).
interface sr_latch_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       S;
  logic       R;
  logic       C;
  logic       q_in;
  logic       nq_in;
  logic       done;
  logic       err_illegal;
  logic       err_readback;
  logic       state_q;
  logic       state_valid;

  modport master (
    output cmd_valid, cmd_op, q_in, nq_in,
    input  cmd_ready, S, R, C, done, err_illegal, err_readback, state_q, state_valid
  );

  modport slave (
    input  cmd_valid, cmd_op, q_in, nq_in,
    output cmd_ready, S, R, C, done, err_illegal, err_readback, state_q, state_valid
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Purpose: turns single-cycle set/clear/refresh commands into framed S/R/C sequences for a gated SR latch.
// Latency: SETUP+PULSE_W+HOLD+1 cycles from acceptance to done (1 cycle for an illegal op).
// Backpressure: cmd_ready is high only in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries cmd_valid/cmd_ready/cmd_op,
//   latch drive S/R/C, readback q_in/nq_in, done with err_illegal/err_readback, and state_q/state_valid.
module sr_latch_driver #(
  parameter int SETUP   = 1,
  parameter int PULSE_W = 2,
  parameter int HOLD    = 1
) (
  input  logic               clk,
  input  logic               rst,
  sr_latch_driver_if.slave   bus
);

  localparam int MAX_PH = (SETUP > PULSE_W) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                            : ((PULSE_W > HOLD) ? PULSE_W : HOLD);
  localparam int CW = $clog2(MAX_PH + 1);

  // Counters hold "cycles remaining minus one" so a phase ends when the count reads zero.
  localparam logic [CW-1:0] SETUP_LD = CW'((SETUP > 0) ? SETUP - 1 : 0);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] OP_REF = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  logic [2:0]    fsm_q,  fsm_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [1:0]    op_q,   op_d;
  logic          s_q,    s_d;
  logic          r_q,    r_d;
  logic          c_q,    c_d;
  logic          done_q, done_d;
  logic          rbq_q,  rbq_d;
  logic          rbnq_q, rbnq_d;
  logic          val_q,  val_d;
  logic          vld_q,  vld_d;

  logic          exp_bit;
  logic          rb_match;
  logic          rb_err;
  logic          upd_val;
  logic          upd_vld;

  // Value the latch should hold after this command; refresh expects what we last confirmed.
  assign exp_bit  = (op_q == OP_SET) ? 1'b1 : ((op_q == OP_CLR) ? 1'b0 : val_q);
  assign rb_match = (rbq_q == exp_bit) && (rbnq_q != exp_bit);

  // Readback verdict, only consumed while in DONE.
  always_comb begin
    rb_err  = 1'b0;
    upd_val = val_q;
    upd_vld = vld_q;
    case (op_q)
      OP_SET, OP_CLR: begin
        if (rb_match) begin
          upd_val = exp_bit;
          upd_vld = 1'b1;
        end else begin
          rb_err  = 1'b1;
          upd_vld = 1'b0;
        end
      end
      OP_REF: begin
        if (vld_q) begin
          if (!rb_match) begin
            rb_err  = 1'b1;
            upd_vld = 1'b0;
          end
        end else if (rbq_q != rbnq_q) begin
          // Unknown state but a consistent readback: learn the latch value.
          upd_val = rbq_q;
          upd_vld = 1'b1;
        end else begin
          rb_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    rbq_d  = rbq_q;
    rbnq_d = rbnq_q;
    val_d  = val_q;
    vld_d  = vld_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d = bus.cmd_op;
          if (bus.cmd_op == OP_ILL) begin
            fsm_d = ST_DONE;
          end else if (SETUP > 0) begin
            fsm_d = ST_SETUP;
            cnt_d = SETUP_LD;
          end else begin
            fsm_d = ST_PULSE;
            cnt_d = PULSE_LD;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          fsm_d = ST_PULSE;
          cnt_d = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          fsm_d = ST_HOLD;
          cnt_d = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          // Sample readback while C is still high, on the edge closing the last HOLD cycle.
          fsm_d  = ST_DONE;
          rbq_d  = bus.q_in;
          rbnq_d = bus.nq_in;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
        if (op_q != OP_ILL) begin
          val_d = upd_val;
          vld_d = upd_vld;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase

    // Drive outputs are registered from the next state so they line up exactly with the phases.
    c_d    = (fsm_d == ST_SETUP) || (fsm_d == ST_PULSE) || (fsm_d == ST_HOLD);
    s_d    = (fsm_d == ST_PULSE) && (op_d == OP_SET);
    r_d    = (fsm_d == ST_PULSE) && (op_d == OP_CLR);
    done_d = (fsm_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      cnt_q  <= '0;
      op_q   <= OP_REF;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
      rbq_q  <= 1'b0;
      rbnq_q <= 1'b0;
      val_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      s_q    <= s_d;
      r_q    <= r_d;
      c_q    <= c_d;
      done_q <= done_d;
      rbq_q  <= rbq_d;
      rbnq_q <= rbnq_d;
      val_q  <= val_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.cmd_ready    = (fsm_q == ST_IDLE) && !rst;
  assign bus.S            = s_q;
  assign bus.R            = r_q;
  assign bus.C            = c_q;
  assign bus.done         = done_q;
  assign bus.err_illegal  = done_q && (op_q == OP_ILL);
  assign bus.err_readback = done_q && (op_q != OP_ILL) && rb_err;
  assign bus.state_q      = val_q;
  assign bus.state_valid  = vld_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_latch_driver_if ifa ();
  sr_latch_driver_if ifb ();

  sr_latch_driver #(.SETUP(1), .PULSE_W(2), .HOLD(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  sr_latch_driver #(.SETUP(0), .PULSE_W(1), .HOLD(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int vec  = 0;
  int errs = 0;

  // Behavioural latch cells (clocked view of a gated SR latch) with injectable readback faults.
  bit lat_a, lat_b, lat_load, init_a, init_b;
  int fault_a = 0, fault_b = 0;

  always @(posedge clk) begin
    if (lat_load)                 lat_a <= init_a;
    else if (ifa.C && ifa.S)      lat_a <= 1'b1;
    else if (ifa.C && ifa.R)      lat_a <= 1'b0;
  end
  always @(posedge clk) begin
    if (lat_load)                 lat_b <= init_b;
    else if (ifb.C && ifb.S)      lat_b <= 1'b1;
    else if (ifb.C && ifb.R)      lat_b <= 1'b0;
  end

  // 0 healthy, 1 stuck Q=nQ=0, 2 stuck Q=nQ=1, 3 inverted wiring.
  function automatic logic [1:0] rb_pair(bit l, int f);
    case (f)
      1:       return 2'b00;
      2:       return 2'b11;
      3:       return {~l, l};
      default: return {l, ~l};
    endcase
  endfunction

  assign {ifa.q_in, ifa.nq_in} = rb_pair(lat_a, fault_a);
  assign {ifb.q_in, ifb.nq_in} = rb_pair(lat_b, fault_b);

  // Reference state: latch contents and the driver's confirmed value per instance.
  bit mlat[2];
  bit mval[2];
  bit mvld[2];

  // Invariant tracking state.
  int pre_c[2];
  int post_c[2];
  bit seen_p[2];
  bit prev_c[2];

  // {cmd_ready, S, R, C, done, err_illegal, err_readback, state_q, state_valid}
  function automatic logic [8:0] obs(int w);
    if (w == 0)
      return {ifa.cmd_ready, ifa.S, ifa.R, ifa.C, ifa.done, ifa.err_illegal, ifa.err_readback,
              ifa.state_q, ifa.state_valid};
    return {ifb.cmd_ready, ifb.S, ifb.R, ifb.C, ifb.done, ifb.err_illegal, ifb.err_readback,
            ifb.state_q, ifb.state_valid};
  endfunction

  function automatic int su_of(int w); return (w == 0) ? 1 : 0; endfunction
  function automatic int pw_of(int w); return (w == 0) ? 2 : 1; endfunction
  function automatic int ho_of(int w); return (w == 0) ? 1 : 3; endfunction

  task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
    vec++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b (rdy,S,R,C,done,eill,erb,sq,sv)", tag, o, e);
    end
  endtask

  task automatic drv(input int w, input logic v, input logic [1:0] op);
    if (w == 0) begin ifa.cmd_valid = v; ifa.cmd_op = op; end
    else        begin ifb.cmd_valid = v; ifb.cmd_op = op; end
  endtask

  // Safety invariants and C framing around every S/R pulse, checked on every sampled cycle.
  task automatic inv_check();
    logic [8:0] o;
    bit s, r, c;
    for (int w = 0; w < 2; w++) begin
      o = obs(w);
      s = o[7]; r = o[6]; c = o[5];
      vec++;
      assert (!(s && r) && (!(s || r) || c)) else begin
        errs++;
        $error("FAIL inv_sr_c w%0d: observed S=%b R=%b C=%b required !(S&R) and (S|R)->C", w, s, r, c);
      end
      if (rst) begin
        pre_c[w] = 0; post_c[w] = 0; seen_p[w] = 0;
      end else begin
        if ((s || r) && !seen_p[w]) begin
          vec++;
          assert (pre_c[w] >= su_of(w)) else begin
            errs++;
            $error("FAIL inv_setup w%0d: observed %0d lead cycles required >= %0d", w, pre_c[w], su_of(w));
          end
          seen_p[w] = 1;
        end
        if (s || r) post_c[w] = 0;
        else if (c && seen_p[w]) post_c[w]++;
        else if (c) pre_c[w]++;
        if (!c && prev_c[w]) begin
          if (seen_p[w]) begin
            vec++;
            assert (post_c[w] >= ho_of(w)) else begin
              errs++;
              $error("FAIL inv_hold w%0d: observed %0d trail cycles required >= %0d", w, post_c[w], ho_of(w));
            end
          end
          pre_c[w] = 0; post_c[w] = 0; seen_p[w] = 0;
        end
      end
      prev_c[w] = c;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    inv_check();
  endtask

  // Issue one command and check every cycle of its timeline plus the state afterwards.
  task automatic run_cmd(input int w, input logic [1:0] op, input int f, input bit busy);
    int su, pw, ho, n;
    logic [1:0] rb;
    bit e_bit, exp_err, nval, nvld;
    logic [8:0] e;
    su = su_of(w); pw = pw_of(w); ho = ho_of(w);
    tick();
    if (w == 0) fault_a = f; else fault_b = f;
    chk($sformatf("w%0d idle_before", w), obs(w), {1'b1, 6'b0, mval[w], mvld[w]});
    drv(w, 1'b1, op);

    if (op == 2'b10) mlat[w] = 1'b1;
    if (op == 2'b01) mlat[w] = 1'b0;
    rb = rb_pair(mlat[w], f);
    exp_err = 0; nval = mval[w]; nvld = mvld[w];
    case (op)
      2'b10, 2'b01: begin
        e_bit = (op == 2'b10);
        if (rb == {e_bit, ~e_bit}) begin nval = e_bit; nvld = 1; end
        else begin exp_err = 1; nvld = 0; end
      end
      2'b00: begin
        if (mvld[w]) begin
          if (rb != {mval[w], ~mval[w]}) begin exp_err = 1; nvld = 0; end
        end else if (rb[1] != rb[0]) begin
          nval = rb[1]; nvld = 1;
        end else begin
          exp_err = 1;
        end
      end
      default: ;
    endcase

    n = (op == 2'b11) ? 1 : su + pw + ho + 1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (op == 2'b11)
        e = {1'b0, 3'b000, 1'b1, 1'b1, 1'b0, mval[w], mvld[w]};
      else
        e = {1'b0,
             (op == 2'b10) && (k > su) && (k <= su + pw),
             (op == 2'b01) && (k > su) && (k <= su + pw),
             (k <= su + pw + ho),
             (k == n), 1'b0, (k == n) && exp_err,
             mval[w], mvld[w]};
      chk($sformatf("w%0d op%0d f%0d cyc%0d", w, op, f, k), obs(w), e);
      if (k == 1) begin
        if (busy) drv(w, 1'b1, 2'($urandom_range(0, 3)));
        else      drv(w, 1'b0, 2'b00);
      end
      if (k == n) drv(w, 1'b0, 2'b00);
    end
    mval[w] = nval; mvld[w] = nvld;
    tick();
    chk($sformatf("w%0d op%0d after", w, op), obs(w), {1'b1, 6'b0, mval[w], mvld[w]});
  endtask

  initial begin
    drv(0, 1'b0, 2'b00);
    drv(1, 1'b0, 2'b00);
    for (int w = 0; w < 2; w++) begin
      pre_c[w] = 0; post_c[w] = 0; seen_p[w] = 0; prev_c[w] = 0; mval[w] = 0; mvld[w] = 0;
    end
    init_a = 1'($urandom_range(0, 1));
    init_b = 1'($urandom_range(0, 1));
    mlat[0] = init_a; mlat[1] = init_b;
    rst = 1'b1; lat_load = 1'b1;
    repeat (2) @(posedge clk);
    tick();
    chk("reset_a", obs(0), 9'b0);
    chk("reset_b", obs(1), 9'b0);
    rst = 1'b0; lat_load = 1'b0;
    tick();
    chk("ready_after_reset_a", obs(0), {1'b1, 8'b0});
    chk("ready_after_reset_b", obs(1), {1'b1, 8'b0});

    // Directed: set, clear, refresh, illegal with a busy request, readback faults.
    run_cmd(0, 2'b10, 0, 0);
    run_cmd(0, 2'b01, 0, 0);
    run_cmd(0, 2'b00, 0, 0);
    run_cmd(0, 2'b11, 0, 0);
    run_cmd(0, 2'b10, 0, 1);
    run_cmd(0, 2'b10, 1, 0);
    run_cmd(0, 2'b00, 1, 0);
    run_cmd(0, 2'b00, 0, 0);

    // Reset during the S pulse aborts without done and forgets the confirmed value.
    tick();
    fault_a = 0;
    drv(0, 1'b1, 2'b10);
    tick();
    drv(0, 1'b0, 2'b00);
    chk("rst_mid_cyc1", obs(0), {1'b0, 3'b001, 3'b000, mval[0], mvld[0]});
    tick();
    chk("rst_mid_cyc2", obs(0), {1'b0, 3'b101, 3'b000, mval[0], mvld[0]});
    rst = 1'b1;
    tick();
    mlat[0] = 1'b1;
    mval[0] = 0; mvld[0] = 0; mval[1] = 0; mvld[1] = 0;
    chk("rst_mid_abort", obs(0), 9'b0);
    rst = 1'b0;
    tick();
    chk("rst_mid_release", obs(0), {1'b1, 8'b0});
    tick();
    chk("rst_mid_no_done", obs(0), {1'b1, 8'b0});

    // Alternate timing instance: SETUP=0, PULSE_W=1, HOLD=3.
    run_cmd(1, 2'b10, 0, 0);
    run_cmd(1, 2'b01, 0, 1);
    run_cmd(1, 2'b00, 0, 0);
    run_cmd(1, 2'b11, 0, 0);

    // Randomized mix on both instances.
    for (int i = 0; i < 40; i++) begin
      int w, f;
      logic [1:0] op;
      w  = $urandom_range(0, 1);
      op = 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_cmd(w, op, f, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
